// File: rtl/mem_access_unit.sv
// Load/store unit between a core request port and a word-wide data memory.
// Sub-word stores are done as read-modify-write; sub-word loads are extended here.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic        wr_en_q;
    logic [31:0] write_data_q;

    function automatic logic is_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic e;
        e = 1'b1;
        case (f3)
            3'b000:  e = 1'b0;
            3'b001:  e = off[0];
            3'b010:  e = |off;
            3'b100:  e = we;
            3'b101:  e = we | off[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = 32'(b);
            3'b001:  r = 32'(h);
            3'b100:  r = {24'b0, b};
            3'b101:  r = {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed byte/halfword; the rest of the word is kept.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] data,
                                                input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] r;
        r = word;
        if (f3 == 3'b000) begin
            case (off)
                2'd0:    r[7:0]   = data[7:0];
                2'd1:    r[15:8]  = data[7:0];
                2'd2:    r[23:16] = data[7:0];
                default: r[31:24] = data[7:0];
            endcase
        end else if (off[1]) begin
            r[31:16] = data;
        end else begin
            r[15:0] = data;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata   <= '0;
            wr_en_q      <= 1'b0;
            write_data_q <= '0;
            mem_addr     <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            wdata_q      <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata   <= '0;
            wr_en_q      <= 1'b0;
            write_data_q <= '0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        funct3_q  <= req_funct3;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata[15:0];
                        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        req_ready <= 1'b0;
                        if (is_err(req_we, req_funct3, req_addr[1:0])) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (!req_we) begin
                            state <= LOAD;
                        end else if (req_funct3 == 3'b010) begin
                            state        <= STORE;
                            wr_en_q      <= 1'b1;
                            write_data_q <= req_wdata;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_rdata   <= load_ext(mem_read_data, off_q, funct3_q);
                end
                STORE: begin
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                end
                RMW_RD: begin
                    state        <= RMW_WR;
                    wr_en_q      <= 1'b1;
                    write_data_q <= store_merge(mem_read_data, wdata_q, off_q, funct3_q);
                end
                RMW_WR: begin
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Reset must suppress a write or response already registered for this cycle.
    assign mem_wr_en      = wr_en_q & ~rst;
    assign mem_write_data = mem_wr_en ? write_data_q : 32'b0;
    assign resp_valid     = resp_valid_q & ~rst;
    assign resp_err       = resp_err_q & ~rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: word memory model plus a response scoreboard.
module tb_mem_access_unit;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    logic [31:0] mem [0:63];
    logic        preload;
    int          errors = 0;
    int          checks = 0;
    int          wr_pulses = 0;
    int          resp_pulses = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
        end else if (mem_wr_en) begin
            mem[mem_addr[7:2]] <= mem_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: pop the scoreboard whenever the DUT responds.
    always @(negedge clk) begin
        if (mem_wr_en) wr_pulses++;
        if (resp_valid) begin
            resp_pulses++;
            check("resp_expected", {31'b0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("resp_rdata", resp_rdata, mon_e.rdata);
                check("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
            end
        end
    end

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_wr);
        int   lat;
        int   wr0;
        exp_t e;
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        wr0        = wr_pulses;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        e.rdata    = exp_rdata;
        e.err      = exp_err;
        sb_q.push_back(e);
        @(posedge clk); #1;
        // Noise on the request port while busy must be ignored.
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_003C;
        req_wdata  = 32'hDEAD_BEEF;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        check({tag, "_latency"}, lat, exp_lat);
        @(posedge clk); #1;
        check({tag, "_pulse_1cyc"}, {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_wr_pulses"}, wr_pulses - wr0, exp_wr);
        check({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, "_wdata_idle"}, mem_write_data, 32'd0);
    endtask

    initial begin
        preload    = 1'b1;
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0010;
        req_wdata  = 32'h0;
        @(negedge clk);
        preload = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        check("rst_no_resp", resp_pulses, 0);
        rst       = 1'b0;
        req_valid = 1'b0;

        do_req("lw_10",  1'b0, 3'b010, 32'h10, 32'h0,        32'h0000_0004, 1'b0, 2, 0);
        do_req("sw_20",  1'b1, 3'b010, 32'h20, 32'h1234_5680, 32'h0,        1'b0, 2, 1);
        check("mem8_sw", mem[8], 32'h1234_5680);
        do_req("lb_20",  1'b0, 3'b000, 32'h20, 32'h0,        32'hFFFF_FF80, 1'b0, 2, 0);
        do_req("lbu_20", 1'b0, 3'b100, 32'h20, 32'h0,        32'h0000_0080, 1'b0, 2, 0);
        do_req("lh_22",  1'b0, 3'b001, 32'h22, 32'h0,        32'h0000_1234, 1'b0, 2, 0);
        do_req("sb_21",  1'b1, 3'b000, 32'h21, 32'h0000_00AB, 32'h0,        1'b0, 3, 1);
        check("mem8_sb", mem[8], 32'h1234_AB80);
        do_req("lw_20",  1'b0, 3'b010, 32'h20, 32'h0,        32'h1234_AB80, 1'b0, 2, 0);
        do_req("lw_22",  1'b0, 3'b010, 32'h22, 32'h0,        32'h0,         1'b1, 1, 0);
        do_req("sh_23",  1'b1, 3'b001, 32'h23, 32'h0000_BEEF, 32'h0,        1'b1, 1, 0);
        check("mem8_err", mem[8], 32'h1234_AB80);

        do_req("sw_24",  1'b1, 3'b010, 32'h24, 32'h8001_FF7F, 32'h0,        1'b0, 2, 1);
        do_req("lhu_26", 1'b0, 3'b101, 32'h26, 32'h0,        32'h0000_8001, 1'b0, 2, 0);
        do_req("lh_26",  1'b0, 3'b001, 32'h26, 32'h0,        32'hFFFF_8001, 1'b0, 2, 0);
        do_req("lb_25",  1'b0, 3'b000, 32'h25, 32'h0,        32'hFFFF_FFFF, 1'b0, 2, 0);
        do_req("lbu_27", 1'b0, 3'b100, 32'h27, 32'h0,        32'h0000_0080, 1'b0, 2, 0);
        do_req("sh_24",  1'b1, 3'b001, 32'h24, 32'h5555_CAFE, 32'h0,        1'b0, 3, 1);
        check("mem9_sh", mem[9], 32'h8001_CAFE);
        do_req("sb_27",  1'b1, 3'b000, 32'h27, 32'hFFFF_FF11, 32'h0,        1'b0, 3, 1);
        check("mem9_sb", mem[9], 32'h1101_CAFE);
        do_req("ld_f011", 1'b0, 3'b011, 32'h24, 32'h0,       32'h0,         1'b1, 1, 0);
        do_req("st_f100", 1'b1, 3'b100, 32'h24, 32'h0000_0077, 32'h0,       1'b1, 1, 0);
        do_req("lh_odd", 1'b0, 3'b001, 32'h25, 32'h0,        32'h0,         1'b1, 1, 0);
        check("mem9_err", mem[9], 32'h1101_CAFE);

        // Reset during the read half of a read-modify-write aborts it.
        begin
            int wr0;
            int rp0;
            wr0        = wr_pulses;
            rp0        = resp_pulses;
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = 3'b001;
            req_addr   = 32'h30;
            req_wdata  = 32'h0000_BEEF;
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("abort_accepted", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            repeat (4) @(negedge clk);
            check("abort_no_wr", wr_pulses - wr0, 0);
            check("abort_no_resp", resp_pulses - rp0, 0);
            check("abort_mem12", mem[12], 32'h0000_000C);
            check("abort_ready", {31'b0, req_ready}, 32'd1);
        end
        do_req("lw_30",  1'b0, 3'b010, 32'h30, 32'h0,        32'h0000_000C, 1'b0, 2, 0);

        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
